// File: rtl/rsa_pkg.sv
// Shared encodings for the RSA operation sequencer: FSM states, last-operation
// codes, error codes and the pending-request record.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    KG_WAIT = 2'b01,
    ME_WAIT = 2'b10
  } state_e;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_GEN  = 2'b01;
  localparam logic [1:0] OP_ENC  = 2'b10;
  localparam logic [1:0] OP_DEC  = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NO_KEY  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Field order gives the service priority, highest first.
  typedef struct packed {
    logic gen;
    logic dec;
    logic enc;
  } req_t;

endpackage

// File: rtl/rsa_op_timeout.sv
// Wait-state watchdog: cleared when a WAIT state is entered, counts while
// enabled and flags the cycle in which the count equals TIMEOUT_CYCLES.
module rsa_op_timeout #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  logic [TO_W-1:0] count_q, count_d;

  assign hit_o = (count_q == TO_W'(TIMEOUT_CYCLES));

  // Next count: clear wins, then saturate at the limit.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {TO_W{1'b0}};
    end else if (en_i && !hit_o) begin
      count_d = count_q + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= {TO_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rsa_op_sequencer.sv
// Serializes gen/encrypt/decrypt requests onto the key generator and modexp
// engine with start/done handshakes, key-before-use checks and a timeout.
module rsa_op_sequencer
  import rsa_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gen,
  input  logic       encrypt,
  input  logic       decrypt,
  output logic       kg_start,
  input  logic       kg_done,
  output logic       me_start,
  output logic       me_use_private,
  input  logic       me_done,
  output logic       abort,
  output logic       busy,
  output logic       key_valid,
  output logic       op_done,
  output logic [1:0] op_code,
  output logic       err,
  output logic [1:0] err_code
);

  state_e     state_q, state_d;
  req_t       pend_q, pend_d, req_s;
  logic       kg_start_q, kg_start_d;
  logic       me_start_q, me_start_d;
  logic       me_priv_q, me_priv_d;
  logic       abort_q, abort_d;
  logic       key_valid_q, key_valid_d;
  logic       op_done_q, op_done_d;
  logic [1:0] op_code_q, op_code_d;
  logic       err_q, err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       wait_s, to_clr_s, to_hit_s;

  assign wait_s = (state_q != IDLE);

  rsa_op_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timeout (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (to_clr_s),
    .en_i  (wait_s),
    .hit_o (to_hit_s)
  );

  // Next-state, request bookkeeping and registered-output decode.
  always_comb begin
    state_d     = state_q;
    req_s       = req_t'(pend_q | {gen, decrypt, encrypt});
    pend_d      = req_s;
    kg_start_d  = 1'b0;
    me_start_d  = 1'b0;
    me_priv_d   = me_priv_q;
    abort_d     = 1'b0;
    key_valid_d = key_valid_q;
    op_done_d   = 1'b0;
    op_code_d   = op_code_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    to_clr_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_s.gen) begin
          pend_d.gen  = 1'b0;
          kg_start_d  = 1'b1;
          key_valid_d = 1'b0;
          op_code_d   = OP_GEN;
          to_clr_s    = 1'b1;
          state_d     = KG_WAIT;
        end else if (req_s.dec || req_s.enc) begin
          if (req_s.dec) begin
            pend_d.dec = 1'b0;
          end else begin
            pend_d.enc = 1'b0;
          end
          // Without a key the request is consumed and reported, not queued.
          if (key_valid_q) begin
            me_start_d = 1'b1;
            me_priv_d  = req_s.dec;
            op_code_d  = req_s.dec ? OP_DEC : OP_ENC;
            to_clr_s   = 1'b1;
            state_d    = ME_WAIT;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_NO_KEY;
            state_d    = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      KG_WAIT: begin
        if (kg_done) begin
          key_valid_d = 1'b1;
          op_done_d   = 1'b1;
          state_d     = IDLE;
        end else if (to_hit_s) begin
          abort_d    = 1'b1;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = IDLE;
        end else begin
          state_d = KG_WAIT;
        end
      end
      ME_WAIT: begin
        if (me_done) begin
          op_done_d = 1'b1;
          state_d   = IDLE;
        end else if (to_hit_s) begin
          abort_d    = 1'b1;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = IDLE;
        end else begin
          state_d = ME_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      kg_start_q  <= 1'b0;
      me_start_q  <= 1'b0;
      me_priv_q   <= 1'b0;
      abort_q     <= 1'b0;
      key_valid_q <= 1'b0;
      op_done_q   <= 1'b0;
      op_code_q   <= OP_NONE;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      kg_start_q  <= kg_start_d;
      me_start_q  <= me_start_d;
      me_priv_q   <= me_priv_d;
      abort_q     <= abort_d;
      key_valid_q <= key_valid_d;
      op_done_q   <= op_done_d;
      op_code_q   <= op_code_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign kg_start       = kg_start_q;
  assign me_start       = me_start_q;
  assign me_use_private = me_priv_q;
  assign abort          = abort_q;
  assign busy           = wait_s;
  assign key_valid      = key_valid_q;
  assign op_done        = op_done_q;
  assign op_code        = op_code_q;
  assign err            = err_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_rsa_op_sequencer.sv
// Self-checking bench for rsa_op_sequencer: vector table, directed multi-cycle
// sequences and random traffic against a request/operation-level model.
module tb_rsa_op_sequencer;

  localparam int T = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, gen = 1'b0, encrypt = 1'b0, decrypt = 1'b0;
  logic kg_done = 1'b0, me_done = 1'b0;
  logic kg_start, me_start, me_use_private, abort, busy, key_valid, op_done, err;
  logic [1:0] op_code, err_code;

  rsa_op_sequencer #(.TIMEOUT_CYCLES(T), .TO_W(11)) dut (
    .clk(clk), .rst(rst), .gen(gen), .encrypt(encrypt), .decrypt(decrypt),
    .kg_start(kg_start), .kg_done(kg_done), .me_start(me_start),
    .me_use_private(me_use_private), .me_done(me_done), .abort(abort),
    .busy(busy), .key_valid(key_valid), .op_done(op_done), .op_code(op_code),
    .err(err), .err_code(err_code)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: which engine is running, for how long, what is pending.
  int         m_mode = 0;   // 0 none, 1 key generation, 2 modexp
  int         m_el   = 0;   // cycles elapsed since the start pulse cycle
  bit         m_pend [3];   // 0 gen, 1 decrypt, 2 encrypt (priority order)
  bit         m_key, m_priv;
  logic [1:0] m_op, m_ecode;
  bit         x_kgs, x_mes, x_abort, x_done, x_err;
  bit         armed = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [11:0] dut_vec();
    return {kg_start, me_start, me_use_private, abort, busy, key_valid,
            op_done, op_code, err, err_code};
  endfunction

  function automatic logic [11:0] model_vec();
    return {x_kgs, x_mes, m_priv, x_abort, m_mode != 0, m_key,
            x_done, m_op, x_err, m_ecode};
  endfunction

  task automatic model_advance();
    bit req [3];
    bit dn;
    int sel;
    x_kgs = 1'b0; x_mes = 1'b0; x_abort = 1'b0; x_done = 1'b0; x_err = 1'b0;
    if (rst) begin
      m_mode = 0; m_el = 0; m_key = 1'b0; m_priv = 1'b0;
      m_op = 2'b00; m_ecode = 2'b00;
      for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
      armed = 1'b1;
      return;
    end
    req[0] = m_pend[0] | gen;
    req[1] = m_pend[1] | decrypt;
    req[2] = m_pend[2] | encrypt;
    for (int i = 0; i < 3; i++) m_pend[i] = req[i];
    if (m_mode == 0) begin
      if (req[0]) begin
        m_pend[0] = 1'b0; x_kgs = 1'b1; m_key = 1'b0; m_op = 2'b01;
        m_mode = 1; m_el = 0;
      end else if (req[1] || req[2]) begin
        sel = req[1] ? 1 : 2;
        m_pend[sel] = 1'b0;
        if (m_key) begin
          x_mes = 1'b1; m_priv = (sel == 1); m_op = (sel == 1) ? 2'b11 : 2'b10;
          m_mode = 2; m_el = 0;
        end else begin
          x_err = 1'b1; m_ecode = 2'b01;
        end
      end
    end else begin
      dn = (m_mode == 1) ? kg_done : me_done;
      if (dn) begin
        if (m_mode == 1) m_key = 1'b1;
        x_done = 1'b1; m_mode = 0;
      end else if (m_el == T) begin
        x_abort = 1'b1; x_err = 1'b1; m_ecode = 2'b10; m_mode = 0;
      end else begin
        m_el++;
      end
    end
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
    cyc++;
    if (armed) chk("model", int'(dut_vec()), int'(model_vec()));
  endtask

  task automatic quiet();
    gen = 1'b0; encrypt = 1'b0; decrypt = 1'b0; kg_done = 1'b0; me_done = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    tick();
    tick();
    chk("reset_outputs", int'(dut_vec()), 0);
    rst = 1'b0;
  endtask

  task automatic get_key();
    gen = 1'b1; tick(); gen = 1'b0;
    tick();
    kg_done = 1'b1; tick(); kg_done = 1'b0;
    chk("get_key_valid", int'(key_valid), 1);
    tick();
  endtask

  typedef struct {
    int key, g, e, d;
    int kgs, mes, priv, bsy, kv, er, ecode, op;
  } vec_t;
  vec_t vt [8];

  int n_done, n_err, n_me, cd, last_priv;
  bit kind;
  logic [5:0] order;
  int n_starts;

  initial begin
    // key, g, e, d | kg_start, me_start, priv, busy, key_valid, err, err_code, op_code
    vt[0] = '{0, 0, 1, 0,  0, 0, 0, 0, 0, 1, 1, 0};
    vt[1] = '{0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0};
    vt[2] = '{0, 1, 0, 0,  1, 0, 0, 1, 0, 0, 0, 1};
    vt[3] = '{1, 0, 1, 0,  0, 1, 0, 1, 1, 0, 0, 2};
    vt[4] = '{1, 0, 0, 1,  0, 1, 1, 1, 1, 0, 0, 3};
    vt[5] = '{1, 0, 1, 1,  0, 1, 1, 1, 1, 0, 0, 3};
    vt[6] = '{1, 1, 1, 0,  1, 0, 0, 1, 0, 0, 0, 1};
    vt[7] = '{0, 1, 0, 1,  1, 0, 0, 1, 0, 0, 0, 1};

    for (int v = 0; v < 8; v++) begin
      do_reset();
      if (vt[v].key != 0) get_key();
      gen = vt[v].g[0]; encrypt = vt[v].e[0]; decrypt = vt[v].d[0];
      tick();
      quiet();
      chk($sformatf("vec%0d_kg_start", v), int'(kg_start), vt[v].kgs);
      chk($sformatf("vec%0d_me_start", v), int'(me_start), vt[v].mes);
      chk($sformatf("vec%0d_priv", v), int'(me_use_private), vt[v].priv);
      chk($sformatf("vec%0d_busy", v), int'(busy), vt[v].bsy);
      chk($sformatf("vec%0d_key_valid", v), int'(key_valid), vt[v].kv);
      chk($sformatf("vec%0d_err", v), int'(err), vt[v].er);
      chk($sformatf("vec%0d_err_code", v), int'(err_code), vt[v].ecode);
      chk($sformatf("vec%0d_op_code", v), int'(op_code), vt[v].op);
    end

    // Encrypt without a key is rejected; error code holds afterwards.
    do_reset();
    repeat (8) tick();
    encrypt = 1'b1; tick(); encrypt = 1'b0;
    chk("nokey_err", int'(err), 1);
    chk("nokey_code", int'(err_code), 1);
    chk("nokey_me_start", int'(me_start), 0);
    chk("nokey_busy", int'(busy), 0);
    tick();
    chk("nokey_err_pulse", int'(err), 0);
    chk("nokey_code_hold", int'(err_code), 1);

    // Key generation: start only in the first cycle, busy until done.
    do_reset();
    gen = 1'b1; tick(); gen = 1'b0;
    chk("kg_start_first", int'(kg_start), 1);
    chk("kg_busy_first", int'(busy), 1);
    for (int i = 12; i <= 30; i++) begin
      tick();
      chk("kg_start_once", int'(kg_start), 0);
      chk("kg_busy_hold", int'(busy), 1);
      if (i == 30) kg_done = 1'b1;
    end
    tick(); kg_done = 1'b0;
    chk("kg_key_valid", int'(key_valid), 1);
    chk("kg_op_done", int'(op_done), 1);
    chk("kg_op_code", int'(op_code), 1);
    chk("kg_busy_drop", int'(busy), 0);

    // Simultaneous gen/encrypt/decrypt: service order gen, decrypt, encrypt.
    do_reset();
    get_key();
    gen = 1'b1; encrypt = 1'b1; decrypt = 1'b1; tick(); quiet();
    n_done = 0; n_err = 0; cd = -1; kind = 1'b0; order = 6'b0; n_starts = 0;
    for (int k = 0; k < 200 && !(n_done == 3 && !busy); k++) begin
      if (kg_start) begin order = {order[3:0], 2'b01}; n_starts++; cd = 3; kind = 1'b0; end
      if (me_start) begin
        order = {order[3:0], me_use_private ? 2'b11 : 2'b10}; n_starts++; cd = 3; kind = 1'b1;
      end
      if (op_done) n_done++;
      if (err) n_err++;
      kg_done = 1'b0; me_done = 1'b0;
      if (cd == 0) begin
        if (kind) me_done = 1'b1; else kg_done = 1'b1;
        cd = -1;
      end else if (cd > 0) begin
        cd--;
      end
      tick();
    end
    quiet();
    chk("prio_order", int'(order), int'(6'b01_11_10));
    chk("prio_starts", n_starts, 3);
    chk("prio_done_count", n_done, 3);
    chk("prio_err_count", n_err, 0);

    // Modexp timeout, then done landing exactly on the timeout cycle.
    do_reset();
    get_key();
    encrypt = 1'b1; tick(); encrypt = 1'b0;
    chk("to_me_start", int'(me_start), 1);
    repeat (T) tick();
    chk("to_no_abort_yet", int'(abort), 0);
    chk("to_busy_at_limit", int'(busy), 1);
    tick();
    chk("to_abort", int'(abort), 1);
    chk("to_err", int'(err), 1);
    chk("to_code", int'(err_code), 2);
    chk("to_busy_drop", int'(busy), 0);
    tick();
    chk("to_abort_pulse", int'(abort), 0);
    chk("to_code_hold", int'(err_code), 2);
    encrypt = 1'b1; tick(); encrypt = 1'b0;
    chk("to2_me_start", int'(me_start), 1);
    repeat (T) tick();
    me_done = 1'b1; tick(); me_done = 1'b0;
    chk("to2_op_done", int'(op_done), 1);
    chk("to2_no_err", int'(err), 0);
    chk("to2_no_abort", int'(abort), 0);
    chk("to2_busy", int'(busy), 0);

    // Key generation timeout leaves no key.
    do_reset();
    get_key();
    gen = 1'b1; tick(); gen = 1'b0;
    chk("kgto_key_cleared", int'(key_valid), 0);
    repeat (T) tick();
    tick();
    chk("kgto_abort", int'(abort), 1);
    chk("kgto_code", int'(err_code), 2);
    chk("kgto_key_valid", int'(key_valid), 0);

    // Two decrypt pulses during key generation merge into one operation.
    do_reset();
    get_key();
    gen = 1'b1; tick(); gen = 1'b0;
    tick();
    decrypt = 1'b1; tick(); decrypt = 1'b0;
    tick();
    decrypt = 1'b1; tick(); decrypt = 1'b0;
    tick();
    kg_done = 1'b1; tick(); kg_done = 1'b0;
    n_me = 0; last_priv = -1; n_err = 0; cd = -1;
    for (int k = 0; k < 20; k++) begin
      if (me_start) begin n_me++; last_priv = int'(me_use_private); cd = 2; end
      if (err) n_err++;
      me_done = 1'b0;
      if (cd == 0) begin me_done = 1'b1; cd = -1; end
      else if (cd > 0) cd--;
      tick();
    end
    quiet();
    chk("merge_me_starts", n_me, 1);
    chk("merge_priv", last_priv, 1);
    chk("merge_err", n_err, 0);

    // Reset in ME_WAIT drops everything; a late me_done is ignored.
    do_reset();
    get_key();
    encrypt = 1'b1; tick(); encrypt = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_outputs", int'(dut_vec()), 0);
    tick(); tick();
    me_done = 1'b1; tick(); me_done = 1'b0;
    chk("rst_stray_done", int'(op_done), 0);
    chk("rst_stray_busy", int'(busy), 0);
    tick();
    chk("rst_after_outputs", int'(dut_vec()), 0);

    // Random traffic, including stray dones and occasional resets.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      gen     = ($urandom_range(39, 0) == 0);
      encrypt = ($urandom_range(14, 0) == 0);
      decrypt = ($urandom_range(14, 0) == 0);
      kg_done = ($urandom_range(11, 0) == 0);
      me_done = ($urandom_range(9, 0) == 0);
      rst     = ($urandom_range(699, 0) == 0);
      tick();
    end
    quiet();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
